axi_sram_slave: RTL and testbench
=================================

Name: axi_sram_slave

Overview:
- AXI responder that terminates the read/write channels driven by the CPU-side AXI master wrapper; used as the memory model in sim and as on-chip SRAM on FPGA.
- Word-addressed synchronous memory behind independent read and write engines.
- Reads: INCR bursts with ID echo. Writes: single-beat with byte strobes.

Parameters:
- ADDR_WIDTH, 14, word-index bits; depth = 2**ADDR_WIDTH 32-bit words.
- ID_WIDTH, 4, ARID/RID width.
- LFSR_SEED, 16'hACE1, stall-generator seed (optional feature only).

Ports:
- S_AXI_ACLK in 1: clock.
- S_AXI_ARESETN in 1: reset, asynchronous, active-low.
- S_AXI_AWADDR in 32: write address.
- S_AXI_AWSIZE in 3: write size; 2 supported, others treated as 2.
- S_AXI_AWVALID in 1 / S_AXI_AWREADY out 1: write-address handshake.
- S_AXI_WDATA in 32: write data.
- S_AXI_WSTRB in 4: byte strobes.
- S_AXI_WVALID in 1 / S_AXI_WREADY out 1: write-data handshake.
- S_AXI_BVALID out 1 / S_AXI_BREADY in 1: write response; response is always OKAY.
- S_AXI_ARID in ID_WIDTH: read ID.
- S_AXI_ARADDR in 32: read address.
- S_AXI_ARLEN in 8: beats minus one.
- S_AXI_ARSIZE in 3: read size; treated as 2.
- S_AXI_ARVALID in 1 / S_AXI_ARREADY out 1: read-address handshake.
- S_AXI_RID out ID_WIDTH: echoed ARID.
- S_AXI_RDATA out 32: read data.
- S_AXI_RLAST out 1: last beat of burst.
- S_AXI_RVALID out 1 / S_AXI_RREADY in 1: read-data handshake.

Behaviour:
- Reset (async assert, sync release):
  - AWREADY=1, WREADY=1, ARREADY=1.
  - BVALID=0, RVALID=0, RLAST=0, RID=0, RDATA=0.
  - Both FSMs return to IDLE; burst counter=0.
  - Memory contents are not cleared.
  - Reset mid-burst or mid-write abandons the transaction; no partial write.
- Word index = addr[ADDR_WIDTH+1:2]. Upper bits are ignored, so addresses alias modulo depth. addr[1:0] is ignored.
- Write FSM, states W_IDLE, W_COMMIT, W_RESP:
  - W_IDLE: AWREADY and WREADY each drop for the rest of the transaction once their own handshake occurs. AW and W may arrive in either order or in the same cycle. Address and data/strobes are latched on their handshakes.
  - When both are latched (the same cycle as the second handshake counts), go to W_COMMIT.
  - W_COMMIT (1 cycle): mem[idx] byte lanes with WSTRB[i]=1 are written; other lanes unchanged. Then go to W_RESP.
  - W_RESP: BVALID=1 until BVALID&BREADY. The cycle after the handshake: BVALID=0, AWREADY=WREADY=1, state W_IDLE.
  - Minimum AW/W handshake to BVALID latency: 2 cycles.
- Read FSM, states R_IDLE, R_DATA:
  - R_IDLE: ARREADY=1. On ARVALID&ARREADY: latch ARID to RID, beats_left=ARLEN, idx=ARADDR word index; ARREADY=0.
  - The next cycle: RVALID=1, RDATA=mem[idx], RLAST=(ARLEN==0).
  - R_DATA: on RVALID&RREADY with beats_left≠0, the next cycle presents mem[idx+1]. idx wraps modulo depth. beats_left decrements; RLAST=(new beats_left==0). Throughput is 1 beat/cycle.
  - While RREADY=0, RDATA/RLAST/RID hold stable.
  - On the RLAST handshake: the next cycle RVALID=0, ARREADY=1, R_IDLE. No AR acceptance overlaps a burst.
- Read/write collision (same word): a read beat fetched in the same cycle as W_COMMIT returns the old data. The write is visible to any fetch one cycle or more later.
- Read and write engines are fully independent; neither stalls the other.
- ARLEN=255 gives 256 beats; the counter does not overflow.

Optional Feature:
- Macro AXI_SLAVE_RAND_STALL_EN.
- When defined: a 16-bit LFSR (seed LFSR_SEED, advancing every cycle) gates each ready/valid output. When lfsr[1:0]==2'b00:
  - AWREADY, WREADY and ARREADY are forced 0 that cycle.
  - A BVALID or RVALID not yet asserted is delayed one more cycle. Once asserted, valid never drops before its handshake.
- When undefined: zero-wait behaviour exactly as above; no LFSR logic is synthesized.

Test Plan:
- Write then read back: write 0xDEADBEEF to 0x100, WSTRB=4'hF → BVALID within 2 cycles. Then AR 0x100, ARLEN=0, ARID=4'h1 → one beat, RDATA=0xDEADBEEF, RID=1, RLAST=1.
- Byte strobes: mem[0x40]=0x11223344, then write 0xAABBCCDD with WSTRB=4'b0101 → readback 0x11BB33DD.
- Write ordering and backpressure: W arrives 3 cycles before AW → exactly one commit. With BREADY held 0 for 5 cycles, BVALID stays 1 and AWREADY stays 0 throughout.
- Burst with wrap: ADDR_WIDTH=4, preload words 14,15,0,1 = 0xE,0xF,0x0,0x1. ARADDR=0x38, ARLEN=3 → beats 0xE,0xF,0x0,0x1 (wrap 15→0); RLAST only on beat 4.
- RREADY toggling 1,0,0,1 during a 4-beat burst → RDATA/RLAST stable while stalled; exactly 4 handshakes; ARREADY returns to 1 the cycle after the last handshake.
- Async reset asserted mid-burst (beat 2 of 4) → RVALID=0 and ARREADY=1 immediately with no clock edge. After release, a new AR at 0x100 returns the pre-reset memory value.

Source files
------------

// File: rtl/axi_sram_slave.sv
// axi_sram_slave
// ----------------------------------------------------------------------------
// AXI responder backed by a word-addressed synchronous SRAM. It serves as the
// memory model in simulation and as on-chip SRAM on FPGA.
//
// Read engine  : INCR bursts (ARLEN+1 beats, 1 beat/cycle), ARID echoed on RID.
// Write engine : single-beat writes with byte strobes, response always OKAY.
// The two engines are fully independent and never stall each other.
//
// Parameters
//   ADDR_WIDTH : word-index bits, depth = 2**ADDR_WIDTH 32-bit words
//   ID_WIDTH   : ARID/RID width
//   LFSR_SEED  : seed of the random stall generator (optional feature only)
//
// Ports
//   S_AXI_ACLK, S_AXI_ARESETN            : clock, async active-low reset
//   S_AXI_AW{ADDR,SIZE,VALID,READY}      : write address channel
//   S_AXI_W{DATA,STRB,VALID,READY}       : write data channel
//   S_AXI_B{VALID,READY}                 : write response channel
//   S_AXI_AR{ID,ADDR,LEN,SIZE,VALID,READY}: read address channel
//   S_AXI_R{ID,DATA,LAST,VALID,READY}    : read data channel
//
// Optional feature
//   AXI_SLAVE_RAND_STALL_EN : when defined, a 16-bit LFSR inserts random wait
//   states on the ready outputs and on the first assertion of BVALID/RVALID.
//   When undefined the slave is zero-wait and no LFSR exists.
// ----------------------------------------------------------------------------
module axi_sram_slave #(
  parameter int          ADDR_WIDTH = 14,
  parameter int          ID_WIDTH   = 4,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                S_AXI_ACLK,
  input  logic                S_AXI_ARESETN,
  input  logic [31:0]         S_AXI_AWADDR,
  input  logic [2:0]          S_AXI_AWSIZE,
  input  logic                S_AXI_AWVALID,
  output logic                S_AXI_AWREADY,
  input  logic [31:0]         S_AXI_WDATA,
  input  logic [3:0]          S_AXI_WSTRB,
  input  logic                S_AXI_WVALID,
  output logic                S_AXI_WREADY,
  output logic                S_AXI_BVALID,
  input  logic                S_AXI_BREADY,
  input  logic [ID_WIDTH-1:0] S_AXI_ARID,
  input  logic [31:0]         S_AXI_ARADDR,
  input  logic [7:0]          S_AXI_ARLEN,
  input  logic [2:0]          S_AXI_ARSIZE,
  input  logic                S_AXI_ARVALID,
  output logic                S_AXI_ARREADY,
  output logic [ID_WIDTH-1:0] S_AXI_RID,
  output logic [31:0]         S_AXI_RDATA,
  output logic                S_AXI_RLAST,
  output logic                S_AXI_RVALID,
  input  logic                S_AXI_RREADY
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} wstate_e;
  typedef enum logic       {R_IDLE, R_DATA}           rstate_e;

  logic [31:0] mem_q [DEPTH];

  // Sizes are fixed at 32 bits and only the word-index bits of the addresses
  // matter; the rest is deliberately dropped.
  logic unused_inputs;
  assign unused_inputs = ^{S_AXI_AWSIZE, S_AXI_ARSIZE,
                           S_AXI_AWADDR[31:ADDR_WIDTH+2], S_AXI_AWADDR[1:0],
                           S_AXI_ARADDR[31:ADDR_WIDTH+2], S_AXI_ARADDR[1:0]};

  // stall is high in cycles where the slave inserts a wait state
  logic stall;

`ifdef AXI_SLAVE_RAND_STALL_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  assign stall = (lfsr_q[1:0] == 2'b00);
`else
  logic [15:0] unused_seed;
  assign unused_seed = LFSR_SEED;
  assign stall       = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Write engine
  // --------------------------------------------------------------------------
  wstate_e               wstate_q, wstate_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic [ADDR_WIDTH-1:0] widx_q, widx_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic                  bseen_q, bseen_d;
  logic                  awready, wready, bvalid, aw_hs, w_hs;

  always_comb begin
    wstate_d  = wstate_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    widx_d    = widx_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bseen_d   = bseen_q;

    // Each ready drops on its own handshake and stays low until the response
    awready = (wstate_q == W_IDLE) && !aw_done_q && !stall;
    wready  = (wstate_q == W_IDLE) && !w_done_q && !stall;
    // A stall may only postpone BVALID before it has first been shown
    bvalid  = (wstate_q == W_RESP) && (bseen_q || !stall);
    aw_hs   = S_AXI_AWVALID && awready;
    w_hs    = S_AXI_WVALID && wready;

    unique case (wstate_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_done_d = 1'b1;
          widx_d    = S_AXI_AWADDR[ADDR_WIDTH+1:2];
        end
        if (w_hs) begin
          w_done_d = 1'b1;
          wdata_d  = S_AXI_WDATA;
          wstrb_d  = S_AXI_WSTRB;
        end
        if (aw_done_d && w_done_d) begin
          wstate_d = W_COMMIT;
        end
      end
      W_COMMIT: begin
        wstate_d = W_RESP;
      end
      W_RESP: begin
        if (bvalid) begin
          bseen_d = 1'b1;
        end
        if (bvalid && S_AXI_BREADY) begin
          wstate_d  = W_IDLE;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          bseen_d   = 1'b0;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      wstate_q  <= W_IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      widx_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bseen_q   <= 1'b0;
    end else begin
      wstate_q  <= wstate_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      widx_q    <= widx_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bseen_q   <= bseen_d;
    end
  end

  // Memory array is never reset. Reset forces W_IDLE asynchronously, so an
  // interrupted write can never reach the commit cycle.
  always_ff @(posedge S_AXI_ACLK) begin
    if (wstate_q == W_COMMIT) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_q[i]) begin
          mem_q[widx_q][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read engine
  // --------------------------------------------------------------------------
  rstate_e               rstate_q, rstate_d;
  logic [ID_WIDTH-1:0]   rid_q, rid_d;
  logic [7:0]            beats_q, beats_d;
  logic [ADDR_WIDTH-1:0] ridx_q, ridx_d;
  logic                  rlast_q, rlast_d;
  logic                  rseen_q, rseen_d;
  logic [31:0]           rdata_q;
  logic                  arready, rvalid, fetch;
  logic [ADDR_WIDTH-1:0] fetch_idx;

  always_comb begin
    rstate_d  = rstate_q;
    rid_d     = rid_q;
    beats_d   = beats_q;
    ridx_d    = ridx_q;
    rlast_d   = rlast_q;
    rseen_d   = rseen_q;
    fetch     = 1'b0;
    fetch_idx = ridx_q;

    arready = (rstate_q == R_IDLE) && !stall;
    rvalid  = (rstate_q == R_DATA) && (rseen_q || !stall);

    unique case (rstate_q)
      R_IDLE: begin
        if (S_AXI_ARVALID && arready) begin
          rid_d     = S_AXI_ARID;
          beats_d   = S_AXI_ARLEN;
          ridx_d    = S_AXI_ARADDR[ADDR_WIDTH+1:2];
          rlast_d   = (S_AXI_ARLEN == 8'd0);
          fetch     = 1'b1;
          fetch_idx = S_AXI_ARADDR[ADDR_WIDTH+1:2];
          rstate_d  = R_DATA;
        end
      end
      R_DATA: begin
        if (rvalid) begin
          rseen_d = 1'b1;
        end
        if (rvalid && S_AXI_RREADY) begin
          if (beats_q != 8'd0) begin
            // Index wraps naturally at the array depth
            beats_d   = beats_q - 8'd1;
            ridx_d    = ridx_q + 1'b1;
            fetch     = 1'b1;
            fetch_idx = ridx_q + 1'b1;
            rlast_d   = (beats_q == 8'd1);
          end else begin
            rstate_d = R_IDLE;
            rlast_d  = 1'b0;
            rseen_d  = 1'b0;
          end
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  // A fetch on the same edge that ends W_COMMIT samples the pre-write word
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rstate_q <= R_IDLE;
      rid_q    <= '0;
      beats_q  <= '0;
      ridx_q   <= '0;
      rlast_q  <= 1'b0;
      rseen_q  <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rstate_q <= rstate_d;
      rid_q    <= rid_d;
      beats_q  <= beats_d;
      ridx_q   <= ridx_d;
      rlast_q  <= rlast_d;
      rseen_q  <= rseen_d;
      if (fetch) begin
        rdata_q <= mem_q[fetch_idx];
      end
    end
  end

  assign S_AXI_AWREADY = awready;
  assign S_AXI_WREADY  = wready;
  assign S_AXI_BVALID  = bvalid;
  assign S_AXI_ARREADY = arready;
  assign S_AXI_RVALID  = rvalid;
  assign S_AXI_RID     = rid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RLAST   = rlast_q;

endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave
// Directed bench for axi_sram_slave built with ADDR_WIDTH=4 so that the
// 16-word array wraps and aliases within a short run.
module tb_axi_sram_slave;

  logic        clk;
  logic        rstN;
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic        bvalid;
  logic        bready;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  int passCount;
  int totalCount;

  axi_sram_slave #(
    .ADDR_WIDTH (4),
    .ID_WIDTH   (4),
    .LFSR_SEED  (16'hACE1)
  ) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rstN),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWSIZE  (awsize),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARID    (arid),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARLEN   (arlen),
    .S_AXI_ARSIZE  (arsize),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RID     (rid),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RLAST   (rlast),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    bit              isWrite;
    logic [31:0]     addr;
    logic [31:0]     data;
    logic [3:0]      strb;
    logic [7:0]      len;
    logic [3:0]      id;
    logic [3:0][31:0] expData;
  } vec_t;

  vec_t vecs[11];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCount++;
    if (act !== exp) begin
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      passCount++;
    end
  endtask

  // Single write with AW and W offered together; returns at the negedge after
  // the B handshake. All tasks start and end on a falling clock edge.
  task automatic applyWrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    int lat;
    bit hsAw;
    bit hsW;
    awaddr  = a;
    wdata   = d;
    wstrb   = s;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    bready  = 1'b1;
    n = 0;
    while ((awvalid || wvalid) && n < 20) begin
      hsAw = awvalid && awready;
      hsW  = wvalid && wready;
      @(negedge clk);
      n++;
      if (hsAw) awvalid = 1'b0;
      if (hsW)  wvalid  = 1'b0;
    end
    lat = 1;
    while (!bvalid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("bLatency", lat, 2);
    @(negedge clk);
    checkOutput("bDropAfterHs", bvalid, 1'b0);
    checkOutput("awReadyAfterB", awready, 1'b1);
    bready  = 1'b0;
    awvalid = 1'b0;
    wvalid  = 1'b0;
  endtask

  // Burst read with RREADY held high, checking every beat against exp
  task automatic readBurst(input logic [31:0] a, input logic [7:0] len, input logic [3:0] id,
                           input logic [3:0][31:0] exp);
    int n;
    int beats;
    araddr  = a;
    arlen   = len;
    arid    = id;
    arvalid = 1'b1;
    rready  = 1'b1;
    n = 0;
    while (!arready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    arvalid = 1'b0;
    beats = 0;
    n = 0;
    while (beats <= int'(len) && n < 50) begin
      if (rvalid && rready) begin
        checkOutput($sformatf("rdata[%0d]", beats), rdata, exp[beats]);
        checkOutput($sformatf("rlast[%0d]", beats), rlast, (beats == int'(len)));
        checkOutput($sformatf("rid[%0d]", beats), rid, id);
        beats++;
      end
      @(negedge clk);
      n++;
    end
    checkOutput("beatCount", beats, int'(len) + 1);
    checkOutput("rvalidAfterLast", rvalid, 1'b0);
    checkOutput("arreadyAfterLast", arready, 1'b1);
    rready = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    if (v.isWrite) begin
      applyWrite(v.addr, v.data, v.strb);
    end else begin
      readBurst(v.addr, v.len, v.id, v.expData);
    end
  endtask

  initial begin
    bit          pat[8];
    int          hs;
    int          cyc;
    bit          prevStall;
    logic [31:0] prevData;
    logic        prevLast;
    logic [3:0][31:0] expB;

    passCount  = 0;
    totalCount = 0;
    rstN    = 1'b0;
    awaddr  = '0;
    awsize  = 3'd2;
    awvalid = 1'b0;
    wdata   = '0;
    wstrb   = '0;
    wvalid  = 1'b0;
    bready  = 1'b0;
    arid    = '0;
    araddr  = '0;
    arlen   = '0;
    arsize  = 3'd2;
    arvalid = 1'b0;
    rready  = 1'b0;

    // Table: word index is addr[5:2], so 0x100, 0x40 and 0x00 share word 0
    vecs[0]  = '{1'b1, 32'h100,  32'hDEADBEEF, 4'hF,    8'd0, 4'h0, '0};
    vecs[1]  = '{1'b0, 32'h100,  32'h0,        4'h0,    8'd0, 4'h1, {96'h0, 32'hDEADBEEF}};
    vecs[2]  = '{1'b1, 32'h40,   32'h11223344, 4'hF,    8'd0, 4'h0, '0};
    vecs[3]  = '{1'b1, 32'h40,   32'hAABBCCDD, 4'b0101, 8'd0, 4'h0, '0};
    vecs[4]  = '{1'b0, 32'h40,   32'h0,        4'h0,    8'd0, 4'h2, {96'h0, 32'h11BB33DD}};
    vecs[5]  = '{1'b1, 32'h38,   32'h0000000E, 4'hF,    8'd0, 4'h0, '0};
    vecs[6]  = '{1'b1, 32'h3C,   32'h0000000F, 4'hF,    8'd0, 4'h0, '0};
    vecs[7]  = '{1'b1, 32'h00,   32'h00000000, 4'hF,    8'd0, 4'h0, '0};
    vecs[8]  = '{1'b1, 32'h04,   32'h00000001, 4'hF,    8'd0, 4'h0, '0};
    vecs[9]  = '{1'b0, 32'h38,   32'h0,        4'h0,    8'd3, 4'h5,
                 {32'h00000001, 32'h00000000, 32'h0000000F, 32'h0000000E}};
    vecs[10] = '{1'b0, 32'h1004, 32'h0,        4'h0,    8'd0, 4'hA, {96'h0, 32'h00000001}};

    // Reset values are visible without any clock edge
    #1;
    checkOutput("rstAwready", awready, 1'b1);
    checkOutput("rstWready", wready, 1'b1);
    checkOutput("rstArready", arready, 1'b1);
    checkOutput("rstBvalid", bvalid, 1'b0);
    checkOutput("rstRvalid", rvalid, 1'b0);
    checkOutput("rstRlast", rlast, 1'b0);
    checkOutput("rstRid", rid, 4'h0);
    checkOutput("rstRdata", rdata, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    checkOutput("postRstArready", arready, 1'b1);
    checkOutput("postRstBvalid", bvalid, 1'b0);

    $display("[TB] applying %0d table vectors", 11);
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i]);
    end

    // W arrives three cycles before AW, then BREADY is withheld
    $display("[TB] write data ahead of address with B backpressure");
    awaddr = 32'h0C;
    wdata  = 32'hCAFE0003;
    wstrb  = 4'hF;
    wvalid = 1'b1;
    checkOutput("wFirstReady", wready, 1'b1);
    @(negedge clk);
    wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput("wReadyHeldLow", wready, 1'b0);
      checkOutput("awReadyWaiting", awready, 1'b1);
      checkOutput("noEarlyBvalid", bvalid, 1'b0);
      if (i < 2) @(negedge clk);
    end
    awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    checkOutput("commitNoBvalid", bvalid, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bvalidHeld", bvalid, 1'b1);
      checkOutput("awReadyDuringB", awready, 1'b0);
      @(negedge clk);
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    checkOutput("bvalidCleared", bvalid, 1'b0);
    checkOutput("awReadyRestored", awready, 1'b1);
    checkOutput("wReadyRestored", wready, 1'b1);
    readBurst(32'h0C, 8'd0, 4'h7, {96'h0, 32'hCAFE0003});

    // RREADY pattern 1,0,0,1 then held high over a wrapping 4-beat burst
    $display("[TB] burst with RREADY stalls");
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    expB = {32'h00000001, 32'h00000000, 32'h0000000F, 32'h0000000E};
    araddr  = 32'h38;
    arlen   = 8'd3;
    arid    = 4'h9;
    arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    hs = 0;
    cyc = 0;
    prevStall = 1'b0;
    prevData = '0;
    prevLast = 1'b0;
    while (hs < 4 && cyc < 30) begin
      rready = (cyc < 8) ? pat[cyc] : 1'b1;
      if (rvalid) begin
        if (prevStall) begin
          checkOutput("stallRdataStable", rdata, prevData);
          checkOutput("stallRlastStable", rlast, prevLast);
        end
        if (rready) begin
          checkOutput($sformatf("stallBeat[%0d]", hs), rdata, expB[hs]);
          checkOutput($sformatf("stallLast[%0d]", hs), rlast, (hs == 3));
          hs++;
          prevStall = 1'b0;
        end else begin
          prevStall = 1'b1;
          prevData  = rdata;
          prevLast  = rlast;
        end
      end
      @(negedge clk);
      cyc++;
    end
    rready = 1'b0;
    checkOutput("stallHandshakes", hs, 4);
    checkOutput("stallArreadyBack", arready, 1'b1);
    checkOutput("stallRvalidLow", rvalid, 1'b0);

    // Async reset in the middle of a burst; memory must survive it
    $display("[TB] asynchronous reset during a burst");
    applyWrite(32'h100, 32'h0BADF00D, 4'hF);
    araddr  = 32'h38;
    arlen   = 8'd3;
    arid    = 4'h4;
    arvalid = 1'b1;
    rready  = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    @(negedge clk);
    checkOutput("midBurstBeat2", rdata, 32'h0000000F);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("asyncRstRvalid", rvalid, 1'b0);
    checkOutput("asyncRstArready", arready, 1'b1);
    checkOutput("asyncRstRlast", rlast, 1'b0);
    rready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    readBurst(32'h100, 8'd0, 4'h3, {96'h0, 32'h0BADF00D});

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
